// File: rtl/bcd_clock_cfg.sv
// HH:MM:SS BCD time-of-day counter with run-time 12/24-hour display,
// range-checked synchronous load, single alarm compare and colon blink.
module bcd_clock_cfg #(
  parameter int unsigned DPNT_W = 2,
  parameter logic [7:0]  RST_HH = 8'h00,
  parameter logic [7:0]  RST_MM = 8'h00,
  parameter logic [7:0]  RST_SS = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_mode24,
  input  logic              i_load,
  input  logic [7:0]        i_set_hh,
  input  logic [7:0]        i_set_mm,
  input  logic [7:0]        i_set_ss,
  input  logic              i_alm_en,
  input  logic [7:0]        i_alm_hh,
  input  logic [7:0]        i_alm_mm,
  output logic [7:0]        o_hh,
  output logic [7:0]        o_mm,
  output logic [7:0]        o_ss,
  output logic              o_pm,
  output logic [DPNT_W-1:0] o_dpnt,
  output logic              o_load_err,
  output logic              o_alarm
);

  logic [3:0] ss_u_q, ss_t_q, mm_u_q, mm_t_q, hh_u_q, hh_t_q;
  logic [3:0] ss_u_d, ss_t_d, mm_u_d, mm_t_d, hh_u_d, hh_t_d;
  logic [DPNT_W-1:0] dpnt_q, dpnt_d;
  logic load_err_q, load_err_d;
  logic alarm_q, alarm_d;

  logic load_ok;
  logic ss_wrap, mm_wrap;
  logic [4:0] hh_bin, hh_12;

  // Load is accepted only for a legal 24-hour BCD time
  assign load_ok = (i_set_hh[7:4] <= 4'd2) && (i_set_hh[3:0] <= 4'd9) &&
                   !((i_set_hh[7:4] == 4'd2) && (i_set_hh[3:0] > 4'd3)) &&
                   (i_set_mm[7:4] <= 4'd5) && (i_set_mm[3:0] <= 4'd9) &&
                   (i_set_ss[7:4] <= 4'd5) && (i_set_ss[3:0] <= 4'd9);

  assign ss_wrap = (ss_t_q == 4'd5) && (ss_u_q == 4'd9);
  assign mm_wrap = (mm_t_q == 4'd5) && (mm_u_q == 4'd9);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ss_u_q     <= RST_SS[3:0];
      ss_t_q     <= RST_SS[7:4];
      mm_u_q     <= RST_MM[3:0];
      mm_t_q     <= RST_MM[7:4];
      hh_u_q     <= RST_HH[3:0];
      hh_t_q     <= RST_HH[7:4];
      dpnt_q     <= '1;
      load_err_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      ss_u_q     <= ss_u_d;
      ss_t_q     <= ss_t_d;
      mm_u_q     <= mm_u_d;
      mm_t_q     <= mm_t_d;
      hh_u_q     <= hh_u_d;
      hh_t_q     <= hh_t_d;
      dpnt_q     <= dpnt_d;
      load_err_q <= load_err_d;
      alarm_q    <= alarm_d;
    end
  end

  // Next state: a valid load wins over the tick; a rejected load lets the tick through
  always_comb begin
    ss_u_d     = ss_u_q;
    ss_t_d     = ss_t_q;
    mm_u_d     = mm_u_q;
    mm_t_d     = mm_t_q;
    hh_u_d     = hh_u_q;
    hh_t_d     = hh_t_q;
    dpnt_d     = dpnt_q;
    load_err_d = 1'b0;
    alarm_d    = 1'b0;

    if (i_load && load_ok) begin
      ss_u_d = i_set_ss[3:0];
      ss_t_d = i_set_ss[7:4];
      mm_u_d = i_set_mm[3:0];
      mm_t_d = i_set_mm[7:4];
      hh_u_d = i_set_hh[3:0];
      hh_t_d = i_set_hh[7:4];
      dpnt_d = '1;
    end else begin
      load_err_d = i_load;
      if (i_en) begin
        dpnt_d = ~dpnt_q;
        if (ss_u_q == 4'd9) begin
          ss_u_d = 4'd0;
          ss_t_d = (ss_t_q == 4'd5) ? 4'd0 : ss_t_q + 4'd1;
        end else begin
          ss_u_d = ss_u_q + 4'd1;
        end
        if (ss_wrap) begin
          if (mm_u_q == 4'd9) begin
            mm_u_d = 4'd0;
            mm_t_d = (mm_t_q == 4'd5) ? 4'd0 : mm_t_q + 4'd1;
          end else begin
            mm_u_d = mm_u_q + 4'd1;
          end
        end
        if (ss_wrap && mm_wrap) begin
          if ((hh_t_q == 4'd2) && (hh_u_q == 4'd3)) begin
            hh_t_d = 4'd0;
            hh_u_d = 4'd0;
          end else if (hh_u_q == 4'd9) begin
            hh_u_d = 4'd0;
            hh_t_d = hh_t_q + 4'd1;
          end else begin
            hh_u_d = hh_u_q + 4'd1;
          end
        end
        alarm_d = i_alm_en && ({hh_t_d, hh_u_d} == i_alm_hh) &&
                  ({mm_t_d, mm_u_d} == i_alm_mm) &&
                  (ss_t_d == 4'd0) && (ss_u_d == 4'd0);
      end
    end
  end

  // Display mapping; the 12-hour fold is done in binary and re-encoded as BCD
  always_comb begin
    hh_bin = 5'(hh_t_q) * 5'd10 + 5'(hh_u_q);
    hh_12  = hh_bin;
    if (hh_bin == 5'd0)
      hh_12 = 5'd12;
    else if (hh_bin > 5'd12)
      hh_12 = hh_bin - 5'd12;

    o_hh = {hh_t_q, hh_u_q};
    if (!i_mode24)
      o_hh = (hh_12 >= 5'd10) ? {4'd1, 4'(hh_12 - 5'd10)} : {4'd0, 4'(hh_12)};
    o_pm = (hh_bin >= 5'd12);
  end

  assign o_mm       = {mm_t_q, mm_u_q};
  assign o_ss       = {ss_t_q, ss_u_q};
  assign o_dpnt     = dpnt_q;
  assign o_load_err = load_err_q;
  assign o_alarm    = alarm_q;

endmodule

// File: tb/tb_bcd_clock_cfg.sv
// Directed bench for bcd_clock_cfg: expectations queued with each stimulus
// step and popped against the outputs one time unit after the clock edge.
module tb_bcd_clock_cfg;

  localparam int unsigned DW = 2;

  logic          clk = 1'b0;
  logic          rst_n, en, mode24, load, alm_en;
  logic [7:0]    set_hh, set_mm, set_ss, alm_hh, alm_mm;
  logic [7:0]    hh, mm, ss;
  logic          pm, load_err, alarm;
  logic [DW-1:0] dpnt;

  typedef struct {
    string         tag;
    logic [26:0]   v;
    bit            chk_dp;
    logic [DW-1:0] dp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bcd_clock_cfg #(.DPNT_W(DW), .RST_HH(8'h00), .RST_MM(8'h00), .RST_SS(8'h00)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_mode24(mode24), .i_load(load),
    .i_set_hh(set_hh), .i_set_mm(set_mm), .i_set_ss(set_ss),
    .i_alm_en(alm_en), .i_alm_hh(alm_hh), .i_alm_mm(alm_mm),
    .o_hh(hh), .o_mm(mm), .o_ss(ss), .o_pm(pm), .o_dpnt(dpnt),
    .o_load_err(load_err), .o_alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic expect_t(input string tag, input logic [7:0] e_hh, input logic [7:0] e_mm,
                          input logic [7:0] e_ss, input logic e_pm, input logic e_err,
                          input logic e_alm, input bit chk_dp, input logic [DW-1:0] e_dp);
    exp_t e;
    e.tag    = tag;
    e.v      = {e_hh, e_mm, e_ss, e_pm, e_err, e_alm};
    e.chk_dp = chk_dp;
    e.dp     = e_dp;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [26:0] obs;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty observed=none required=entry");
      return;
    end
    e   = sb.pop_front();
    obs = {hh, mm, ss, pm, load_err, alarm};
    assert (obs === e.v) else begin
      n_bad++;
      $error("FAIL %s hh:mm:ss/pm/err/alm observed=%h:%h:%h/%b/%b/%b required=%h:%h:%h/%b/%b/%b",
             e.tag, obs[26:19], obs[18:11], obs[10:3], obs[2], obs[1], obs[0],
             e.v[26:19], e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
    end
    if (e.chk_dp) begin
      n_cmp++;
      assert (dpnt === e.dp) else begin
        n_bad++;
        $error("FAIL %s_dpnt observed=%b required=%b", e.tag, dpnt, e.dp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic tick);
    load = 1'b1; set_hh = h; set_mm = m; set_ss = s; en = tick;
    step();
    load = 1'b0; en = 1'b0;
  endtask

  task automatic do_tick();
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode24 = 1'b1; load = 1'b0; alm_en = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00; alm_hh = 8'h00; alm_mm = 8'h00;

    // Reset defaults
    step(); step();
    expect_t("in_reset", 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 2'b11); check();
    rst_n = 1'b1; step();
    expect_t("rst_24h", 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 2'b11); check();
    mode24 = 1'b0; #1;
    expect_t("rst_12h", 8'h12, 8'h00, 8'h00, 0, 0, 0, 0, 2'b11); check();
    mode24 = 1'b1; #1;

    // Day wrap and noon
    do_load(8'h23, 8'h59, 8'h59, 0);
    expect_t("ld_235959", 8'h23, 8'h59, 8'h59, 1, 0, 0, 1, 2'b11); check();
    do_tick();
    expect_t("day_wrap", 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00); check();
    do_load(8'h11, 8'h59, 8'h59, 0);
    expect_t("ld_115959", 8'h11, 8'h59, 8'h59, 0, 0, 0, 1, 2'b11); check();
    do_tick();
    expect_t("noon_24h", 8'h12, 8'h00, 8'h00, 1, 0, 0, 1, 2'b00); check();
    mode24 = 1'b0; #1;
    expect_t("noon_12h", 8'h12, 8'h00, 8'h00, 1, 0, 0, 0, 2'b00); check();
    mode24 = 1'b1; #1;

    // BCD carries
    do_load(8'h09, 8'h09, 8'h59, 0);
    do_tick();
    expect_t("carry_0910", 8'h09, 8'h10, 8'h00, 0, 0, 0, 0, 2'b00); check();
    do_load(8'h19, 8'h59, 8'h59, 0);
    do_tick();
    expect_t("carry_2000", 8'h20, 8'h00, 8'h00, 1, 0, 0, 1, 2'b00); check();

    // Load priority and rejected loads
    do_load(8'h12, 8'h34, 8'h56, 1);
    expect_t("ld_with_tick", 8'h12, 8'h34, 8'h56, 1, 0, 0, 1, 2'b11); check();
    do_load(8'h24, 8'h00, 8'h00, 0);
    expect_t("bad_hh24", 8'h12, 8'h34, 8'h56, 1, 1, 0, 1, 2'b11); check();
    step();
    expect_t("err_one_cyc", 8'h12, 8'h34, 8'h56, 1, 0, 0, 0, 2'b11); check();
    do_load(8'h10, 8'h6A, 8'h00, 1);
    expect_t("bad_mm6a_tick", 8'h12, 8'h34, 8'h57, 1, 1, 0, 1, 2'b00); check();
    step();
    expect_t("err_clear", 8'h12, 8'h34, 8'h57, 1, 0, 0, 0, 2'b00); check();

    // Mode switch every cycle
    do_load(8'h15, 8'h07, 8'h30, 0);
    for (int i = 0; i < 4; i++) begin
      mode24 = i[0]; #1;
      expect_t("mode_sw", mode24 ? 8'h15 : 8'h03, 8'h07, 8'h30, 1, 0, 0, 0, 2'b11); check();
      step();
    end
    mode24 = 1'b1; #1;

    // Alarm
    alm_hh = 8'h07; alm_mm = 8'h00; alm_en = 1'b1;
    do_load(8'h06, 8'h59, 8'h58, 0);
    expect_t("alm_ld", 8'h06, 8'h59, 8'h58, 0, 0, 0, 0, 2'b11); check();
    do_tick();
    expect_t("alm_pre", 8'h06, 8'h59, 8'h59, 0, 0, 0, 0, 2'b11); check();
    do_tick();
    expect_t("alm_hit", 8'h07, 8'h00, 8'h00, 0, 0, 1, 0, 2'b11); check();
    step();
    expect_t("alm_one_cyc", 8'h07, 8'h00, 8'h00, 0, 0, 0, 0, 2'b11); check();
    alm_en = 1'b0;
    do_load(8'h06, 8'h59, 8'h58, 0);
    do_tick();
    do_tick();
    expect_t("alm_disabled", 8'h07, 8'h00, 8'h00, 0, 0, 0, 0, 2'b11); check();
    alm_en = 1'b1;
    do_load(8'h07, 8'h00, 8'h00, 0);
    expect_t("alm_by_load", 8'h07, 8'h00, 8'h00, 0, 0, 0, 0, 2'b11); check();

    // Reset overrides load/tick and clears a pending error pulse
    do_load(8'h24, 8'h00, 8'h00, 0);
    expect_t("pre_rst_err", 8'h07, 8'h00, 8'h00, 0, 1, 0, 0, 2'b11); check();
    rst_n = 1'b0;
    do_load(8'h10, 8'h00, 8'h00, 1);
    expect_t("rst_midop", 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 2'b11); check();
    rst_n = 1'b1;
    step();

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
